mer_meter: RTL and testbench
============================

Name: mer_meter

Overview:
- Parametrised 4-ASK modulation-error-ratio measurement block.
- Slices the decision variable against a reference level and compares the result with a delay-aligned copy of the transmitted symbol.
- Per-symbol outputs: error, sym_correct, sym_error.
- Accumulates squared error and symbol-error count over a window of 2^LOG2_WINDOW symbols, then publishes mean-square error and error count.
- Sits after the receive filter / decision point, fed by the same symbol-rate enable as the mapper and slicer.

Parameters:
- WIDTH, 18, width of dec_var, ref_level and error (signed).
- MAX_DELAY, 8, depth of the reference-symbol delay line; delay_sel range is 0..MAX_DELAY-1.
- LOG2_WINDOW, 10, log2 of measurement window length in symbols.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- sym_clk_en  in  1  symbol-rate enable; one clk wide; never asserted on two consecutive clk cycles.
- run  in  1  1 = measure; 0 = return to IDLE.
- dd_mode  in  1  0 = data-aided error (vs mapped delayed ref); 1 = decision-directed error (vs mapped slice).
- delay_sel  in  clog2(MAX_DELAY)  alignment delay, in symbols, for ref_sym.
- ref_sym  in  2  transmitted symbol code.
- ref_level  in  WIDTH signed  inner level magnitude a (>0).
- dec_var  in  WIDTH signed  received decision variable.
- slice  out  2  registered slicer decision.
- error  out  WIDTH signed  registered error sample.
- sym_correct  out  1  registered; 1 when slice equals the aligned ref.
- sym_error  out  1  registered; always ~sym_correct.
- err_power  out  2*WIDTH  mean-square error of the last complete window.
- err_count  out  LOG2_WINDOW+1  symbol errors in the last complete window.
- meas_valid  out  1  one-clk pulse when err_power/err_count update.
- clear_accum  out  1  one-clk pulse when the accumulators restart.

Behaviour:
- Mapping: 00→-3a, 01→-a, 10→+a, 11→+3a.
  - 3a = (a<<1)+a, computed at WIDTH+2 bits.
- Slicer (combinational on dec_var):
  - dec_var ≥ 2a → 11;
  - else ≥ 0 → 10;
  - else ≥ -2a → 01;
  - else 00.
  - Ties resolve upward.
- Delay line: shift register of ref_sym, advanced on sym_clk_en. The aligned ref at tick k is ref_sym(k-delay_sel); delay_sel=0 means the current ref_sym.
- error = dec_var − map(aligned ref) when dd_mode=0, else dec_var − map(slice).
  - Computed at WIDTH+2 bits, then saturated to WIDTH.
- Per-symbol outputs: slice, error, sym_correct and sym_error register on sym_clk_en and hold otherwise. Latency is 1 symbol tick, in every state.
- Reset values:
  - slice=0, error=0, sym_correct=1, sym_error=0;
  - err_power=0, err_count=0, meas_valid=0, clear_accum=0;
  - delay line all 0; FSM in IDLE; accumulators and counters 0.
- FSM states: IDLE, FLUSH, ACCUM.
- IDLE:
  - Accumulators held at 0.
  - When run=1, latch delay_sel and dd_mode into shadow registers, load flush counter = delay_sel, go to FLUSH.
  - delay_sel/dd_mode changes are ignored outside IDLE.
- FLUSH:
  - Decrement the counter on each sym_clk_en.
  - On the tick where the counter is 0, go to ACCUM; that tick is not accumulated.
  - This guarantees the delay line holds valid symbols.
- ACCUM, on each sym_clk_en:
  - acc_sq += error_next²;
  - cnt_err += ~match;
  - sym_cnt++.
  - acc_sq width is 2*WIDTH+LOG2_WINDOW, with no overflow possible.
- Terminal tick (sym_cnt reaches 2^LOG2_WINDOW−1 before increment, i.e. the window's last symbol):
  - err_power ← (acc_sq + term) >> LOG2_WINDOW;
  - err_count ← cnt_err + term;
  - accumulators and sym_cnt ← 0 in the same cycle, so no symbols are lost between windows.
  - meas_valid and clear_accum pulse high on the following clk cycle.
  - Remain in ACCUM.
- run=0 in FLUSH or ACCUM: go to IDLE on the next clk cycle and discard the partial window. err_power/err_count keep the last completed values; no meas_valid pulse.
- Reset mid-window: all state returns to reset values on the next clk edge; no outputs are published.
- ref_level=0 is legal: the slicer degenerates to a sign test and the mapping is all zeros.

Test Plan:
- LOG2_WINDOW=4, a=4096, delay_sel=2, dd_mode=0, dec_var = map(ref_sym 2 ticks earlier), random ref_sym, run=1 → sym_correct=1 every tick; after 2+1 flush ticks and 16 ACCUM ticks, meas_valid pulses with err_power=0, err_count=0.
- Same setup, dec_var offset +100 → error=+100 each tick, err_power=10000, err_count=0.
- Same setup, every 4th symbol sent as the opposite-sign outer level (11↔00) → err_count=4 per window; err_power = (4·24576²)/16.
- Boundary: a=4096, dec_var=8192 → slice=11; dec_var=0 → 10; dec_var=-8192 → 01; dec_var=-8193 → 00. Saturation: dec_var=+131071 with ref 00 → error=+131071.
- Reset asserted at ACCUM symbol 9 → next cycle all outputs at reset values; after run re-asserted, the first meas_valid arrives after a full flush plus 16 ticks.
- run dropped at ACCUM symbol 7 → IDLE, no meas_valid, err_power/err_count unchanged; delay_sel changed in ACCUM has no effect until the next IDLE exit.

Source files
------------

// File: rtl/mer_meter_if.sv
// Symbol-rate stimulus and measurement results exchanged with mer_meter.
// master drives the receive-side inputs; slave is the meter itself.
interface mer_meter_if #(
    parameter int WIDTH       = 18,
    parameter int MAX_DELAY   = 8,
    parameter int LOG2_WINDOW = 10
);
    localparam int DW = $clog2(MAX_DELAY);

    logic                     sym_clk_en;
    logic                     run;
    logic                     dd_mode;
    logic [DW-1:0]            delay_sel;
    logic [1:0]               ref_sym;
    logic signed [WIDTH-1:0]  ref_level;
    logic signed [WIDTH-1:0]  dec_var;
    logic [1:0]               slice;
    logic signed [WIDTH-1:0]  error;
    logic                     sym_correct;
    logic                     sym_error;
    logic [2*WIDTH-1:0]       err_power;
    logic [LOG2_WINDOW:0]     err_count;
    logic                     meas_valid;
    logic                     clear_accum;

    modport master (
        output sym_clk_en, run, dd_mode, delay_sel, ref_sym, ref_level, dec_var,
        input  slice, error, sym_correct, sym_error, err_power, err_count,
               meas_valid, clear_accum
    );

    modport slave (
        input  sym_clk_en, run, dd_mode, delay_sel, ref_sym, ref_level, dec_var,
        output slice, error, sym_correct, sym_error, err_power, err_count,
               meas_valid, clear_accum
    );
endinterface

// File: rtl/mer_meter.sv
// 4-ASK slicer and error generator with windowed mean-square-error and symbol-error measurement.
// Per-symbol results register on sym_clk_en; window results publish every 2^LOG2_WINDOW symbols.
module mer_meter #(
    parameter int WIDTH       = 18,
    parameter int MAX_DELAY   = 8,
    parameter int LOG2_WINDOW = 10
) (
    input logic        clk,
    input logic        reset,
    mer_meter_if.slave bus
);
    localparam int DW = $clog2(MAX_DELAY);
    localparam int XW = WIDTH + 2;
    localparam int PW = 2 * WIDTH;
    localparam int AW = PW + LOG2_WINDOW;

    typedef enum logic [1:0] {IDLE, FLUSH, ACCUM} state_t;
    state_t state, state_next;

    logic [1:0]             dl [MAX_DELAY-1];
    logic [DW-1:0]          delay_sh, flush_cnt, delay_eff;
    logic                   dd_sh, dd_eff;
    logic [AW-1:0]          acc_sq, acc_next;
    logic [LOG2_WINDOW:0]   cnt_err, cnt_next;
    logic [LOG2_WINDOW-1:0] sym_cnt;

    logic signed [XW-1:0]   a_x, a2_x, a3_x, dec_x, err_x;
    logic [1:0]             slice_next, ref_aligned, err_sym;
    logic signed [WIDTH-1:0] err_next;
    logic signed [PW-1:0]   err_wide;
    logic [PW-1:0]          sq;
    logic                   match, miss;
    logic                   start, flush_dec, accum_tick, term_tick;

    function automatic logic signed [XW-1:0] map_sym(input logic [1:0] s,
                                                     input logic signed [XW-1:0] a,
                                                     input logic signed [XW-1:0] a3);
        case (s)
            2'b00:   return -a3;
            2'b01:   return -a;
            2'b10:   return a;
            default: return a3;
        endcase
    endfunction

    // Shadowed alignment/mode are only live in IDLE so a running window cannot be disturbed.
    always_comb begin
        delay_eff = (state == IDLE) ? bus.delay_sel : delay_sh;
        dd_eff    = (state == IDLE) ? bus.dd_mode   : dd_sh;

        a_x   = XW'(bus.ref_level);
        a2_x  = a_x <<< 1;
        a3_x  = a2_x + a_x;
        dec_x = XW'(bus.dec_var);

        if (dec_x >= a2_x)      slice_next = 2'b11;
        else if (!dec_x[XW-1])  slice_next = 2'b10;
        else if (dec_x >= -a2_x) slice_next = 2'b01;
        else                    slice_next = 2'b00;

        ref_aligned = bus.ref_sym;
        for (int unsigned i = 1; i < MAX_DELAY; i++)
            if (delay_eff == DW'(i)) ref_aligned = dl[i-1];

        err_sym = dd_eff ? slice_next : ref_aligned;
        err_x   = dec_x - map_sym(err_sym, a_x, a3_x);

        if (err_x[XW-1:WIDTH-1] == '0 || err_x[XW-1:WIDTH-1] == '1)
            err_next = $signed(err_x[WIDTH-1:0]);
        else if (err_x[XW-1])
            err_next = {1'b1, {(WIDTH-1){1'b0}}};
        else
            err_next = {1'b0, {(WIDTH-1){1'b1}}};

        err_wide = PW'(err_next);
        sq       = $unsigned(err_wide * err_wide);
        match    = (slice_next == ref_aligned);
        miss     = ~match;
        acc_next = acc_sq + AW'(sq);
        cnt_next = cnt_err + (LOG2_WINDOW+1)'(miss);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        flush_dec  = 1'b0;
        accum_tick = 1'b0;
        term_tick  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.run) begin
                    state_next = FLUSH;
                    start      = 1'b1;
                end
            end
            FLUSH: begin
                if (!bus.run)
                    state_next = IDLE;
                else if (bus.sym_clk_en) begin
                    if (flush_cnt == '0) state_next = ACCUM;
                    else                 flush_dec  = 1'b1;
                end
            end
            ACCUM: begin
                if (!bus.run)
                    state_next = IDLE;
                else if (bus.sym_clk_en) begin
                    accum_tick = 1'b1;
                    term_tick  = (sym_cnt == '1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < MAX_DELAY - 1; i++) dl[i] <= '0;
            bus.slice       <= '0;
            bus.error       <= '0;
            bus.sym_correct <= 1'b1;
            bus.sym_error   <= 1'b0;
            bus.err_power   <= '0;
            bus.err_count   <= '0;
            bus.meas_valid  <= 1'b0;
            bus.clear_accum <= 1'b0;
            delay_sh        <= '0;
            dd_sh           <= 1'b0;
            flush_cnt       <= '0;
            acc_sq          <= '0;
            cnt_err         <= '0;
            sym_cnt         <= '0;
        end else begin
            bus.meas_valid  <= 1'b0;
            bus.clear_accum <= 1'b0;

            if (bus.sym_clk_en) begin
                dl[0] <= bus.ref_sym;
                for (int unsigned i = 1; i < MAX_DELAY - 1; i++) dl[i] <= dl[i-1];
                bus.slice       <= slice_next;
                bus.error       <= err_next;
                bus.sym_correct <= match;
                bus.sym_error   <= miss;
            end

            if (start) begin
                delay_sh  <= bus.delay_sel;
                dd_sh     <= bus.dd_mode;
                flush_cnt <= bus.delay_sel;
            end else if (flush_dec) begin
                flush_cnt <= flush_cnt - DW'(1);
            end

            // Terminal symbol is folded into the published result and the next window starts clean.
            if (term_tick) begin
                bus.err_power   <= acc_next[AW-1:LOG2_WINDOW];
                bus.err_count   <= cnt_next;
                bus.meas_valid  <= 1'b1;
                bus.clear_accum <= 1'b1;
                acc_sq          <= '0;
                cnt_err         <= '0;
                sym_cnt         <= '0;
            end else if (accum_tick) begin
                acc_sq  <= acc_next;
                cnt_err <= cnt_next;
                sym_cnt <= sym_cnt + LOG2_WINDOW'(1);
            end else if (state_next != ACCUM) begin
                acc_sq  <= '0;
                cnt_err <= '0;
                sym_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mer_meter.sv
// Bench for mer_meter: constant vector table, directed window/reset/abort sequences,
// and randomized runs checked against a symbol-level reference model.
module tb_mer_meter;
    localparam int WIDTH       = 18;
    localparam int MAX_DELAY   = 8;
    localparam int LOG2_WINDOW = 4;
    localparam int WIN         = 1 << LOG2_WINDOW;
    localparam int SMAX        = (1 << (WIDTH-1)) - 1;
    localparam int SMIN        = -(1 << (WIDTH-1));

    logic clk = 1'b0;
    logic reset = 1'b1;

    mer_meter_if #(.WIDTH(WIDTH), .MAX_DELAY(MAX_DELAY), .LOG2_WINDOW(LOG2_WINDOW)) bus();

    mer_meter #(.WIDTH(WIDTH), .MAX_DELAY(MAX_DELAY), .LOG2_WINDOW(LOG2_WINDOW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_fail = 0;
    int     hist [MAX_DELAY-1];
    bit     m_active, m_dd, last_mv;
    int     m_delay, m_skip, m_n, m_err;
    longint m_acc, m_pwr, m_cnt;

    typedef struct {
        int a; bit dd; int dec; int rs; int slc; int err; bit ok;
    } vec_t;
    vec_t tbl [13];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int map_i(input int s, input int a);
        case (s)
            0:       return -3 * a;
            1:       return -a;
            2:       return a;
            default: return 3 * a;
        endcase
    endfunction

    function automatic int slice_ref(input int d, input int a);
        if (d >= 2 * a)  return 3;
        if (d >= 0)      return 2;
        if (d >= -2 * a) return 1;
        return 0;
    endfunction

    function automatic int sat(input int e);
        if (e > SMAX) return SMAX;
        if (e < SMIN) return SMIN;
        return e;
    endfunction

    function automatic int clampv(input int v);
        return sat(v);
    endfunction

    function automatic int aligned(input int rs);
        int d;
        d = m_active ? m_delay : int'(bus.delay_sel);
        return (d == 0) ? rs : hist[d-1];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < MAX_DELAY - 1; i++) hist[i] = 0;
        m_active = 0; m_acc = 0; m_n = 0; m_err = 0; m_pwr = 0; m_cnt = 0; m_skip = 0;
    endtask

    // One symbol: drive on negedge, check one cycle after the enabled edge, then an idle cycle.
    task automatic sym_tick(input int rs, input int dv);
        int a, al, sl, e, es;
        bit miss, exp_mv;
        @(negedge clk);
        bus.ref_sym    = rs[1:0];
        bus.dec_var    = dv[WIDTH-1:0];
        bus.sym_clk_en = 1'b1;
        a  = int'(bus.ref_level);
        al = aligned(rs);
        sl = slice_ref(dv, a);
        es = (m_active ? m_dd : bus.dd_mode) ? sl : al;
        e  = sat(dv - map_i(es, a));
        miss = (sl != al);
        exp_mv = 0;
        if (m_active) begin
            if (m_skip > 0) m_skip--;
            else begin
                m_acc += longint'(e) * longint'(e);
                m_err += int'(miss);
                m_n++;
                if (m_n == WIN) begin
                    m_pwr = m_acc / WIN;
                    m_cnt = m_err;
                    exp_mv = 1;
                    m_acc = 0; m_err = 0; m_n = 0;
                end
            end
        end
        for (int i = MAX_DELAY - 2; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = rs;
        @(posedge clk); #1;
        bus.sym_clk_en = 1'b0;
        chk("slice", bus.slice, sl);
        chk("error", bus.error, e);
        chk("sym_correct", bus.sym_correct, !miss);
        chk("sym_error", bus.sym_error, miss);
        chk("meas_valid", bus.meas_valid, exp_mv);
        chk("clear_accum", bus.clear_accum, exp_mv);
        chk("err_power", bus.err_power, m_pwr);
        chk("err_count", bus.err_count, m_cnt);
        last_mv = bus.meas_valid;
        @(posedge clk); #1;
        chk("meas_valid_idle", bus.meas_valid, 0);
    endtask

    task automatic start_run(input int ds, input bit dd);
        @(negedge clk);
        bus.delay_sel = ds[$clog2(MAX_DELAY)-1:0];
        bus.dd_mode   = dd;
        bus.run       = 1'b1;
        @(posedge clk); #1;
        m_active = 1; m_delay = ds; m_dd = dd; m_skip = ds + 1;
        m_acc = 0; m_n = 0; m_err = 0;
    endtask

    task automatic stop_run();
        @(negedge clk);
        bus.run = 1'b0;
        @(posedge clk); #1;
        m_active = 0; m_acc = 0; m_n = 0; m_err = 0;
    endtask

    // Ticks with dec_var = mapped aligned ref + offset until a window publishes (bounded).
    task automatic ticks_to_mv(input int off, output int k);
        int rs;
        k = 0;
        for (int t = 1; t <= 40; t++) begin
            rs = int'($urandom_range(0, 3));
            sym_tick(rs, clampv(map_i(aligned(rs), int'(bus.ref_level)) + off));
            if (last_mv) begin k = t; break; end
        end
    endtask

    task automatic exact_ticks(input int n, input int off);
        int rs;
        for (int t = 0; t < n; t++) begin
            rs = int'($urandom_range(0, 3));
            sym_tick(rs, clampv(map_i(aligned(rs), int'(bus.ref_level)) + off));
        end
    endtask

    initial begin
        int k, rs, al, dv, nz, ds, nt;
        bit dd;
        tbl[0]  = '{4096,    1'b0,    8192, 3, 3,   -4096, 1'b1};
        tbl[1]  = '{4096,    1'b0,       0, 2, 2,   -4096, 1'b1};
        tbl[2]  = '{4096,    1'b0,   -8192, 1, 1,   -4096, 1'b1};
        tbl[3]  = '{4096,    1'b0,   -8193, 0, 0,    4095, 1'b1};
        tbl[4]  = '{4096,    1'b0,  131071, 0, 3,  131071, 1'b0};
        tbl[5]  = '{4096,    1'b0, -131072, 3, 0, -131072, 1'b0};
        tbl[6]  = '{4096,    1'b0,    8191, 3, 2,   -4097, 1'b0};
        tbl[7]  = '{4096,    1'b0,      -1, 2, 1,   -4097, 1'b0};
        tbl[8]  = '{0,       1'b0,       5, 1, 3,       5, 1'b0};
        tbl[9]  = '{0,       1'b0,      -1, 0, 0,      -1, 1'b1};
        tbl[10] = '{4096,    1'b1,    5000, 0, 2,     904, 1'b0};
        tbl[11] = '{4096,    1'b1,  -20000, 0, 0,   -7712, 1'b1};
        tbl[12] = '{131071,  1'b0, -131072, 3, 1, -131072, 1'b0};

        bus.sym_clk_en = 1'b0; bus.run = 1'b0; bus.dd_mode = 1'b0; bus.delay_sel = '0;
        bus.ref_sym = '0; bus.ref_level = 18'sd4096; bus.dec_var = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_slice", bus.slice, 0);
        chk("rst_error", bus.error, 0);
        chk("rst_sym_correct", bus.sym_correct, 1);
        chk("rst_sym_error", bus.sym_error, 0);
        chk("rst_err_power", bus.err_power, 0);
        chk("rst_err_count", bus.err_count, 0);
        chk("rst_meas_valid", bus.meas_valid, 0);
        chk("rst_clear_accum", bus.clear_accum, 0);
        reset = 1'b0;

        // Constant vectors, evaluated in IDLE with no alignment delay.
        for (int i = 0; i < 13; i++) begin
            bus.ref_level = tbl[i].a[WIDTH-1:0];
            bus.dd_mode   = tbl[i].dd;
            bus.delay_sel = '0;
            sym_tick(tbl[i].rs, tbl[i].dec);
            chk("vec_slice", bus.slice, tbl[i].slc);
            chk("vec_error", bus.error, tbl[i].err);
            chk("vec_correct", bus.sym_correct, tbl[i].ok);
        end

        // Perfectly aligned symbols: first window after delay+1 flush ticks.
        bus.ref_level = 18'sd4096;
        start_run(2, 1'b0);
        ticks_to_mv(0, k);
        chk("clean_latency", k, 19);
        chk("clean_power", bus.err_power, 0);
        chk("clean_count", bus.err_count, 0);

        // Constant +100 offset over the following contiguous window.
        exact_ticks(WIN, 100);
        chk("offset_mv", last_mv, 1);
        chk("offset_error", bus.error, 100);
        chk("offset_power", bus.err_power, 10000);
        chk("offset_count", bus.err_count, 0);

        // Outer-level symbols, every 4th one sent as the opposite outer level.
        for (int t = 0; t < WIN; t++) begin
            rs = ($urandom_range(0, 1) == 0) ? 0 : 3;
            al = aligned(rs);
            dv = (t % 4 == 3) ? map_i(3 - al, 4096) : map_i(al, 4096);
            sym_tick(rs, dv);
        end
        chk("flip_mv", last_mv, 1);
        chk("flip_power", bus.err_power, 150994944);
        chk("flip_count", bus.err_count, 4);

        // Reset part-way through a window.
        exact_ticks(9, 0);
        @(negedge clk);
        reset = 1'b1;
        bus.run = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_slice", bus.slice, 0);
        chk("mid_rst_error", bus.error, 0);
        chk("mid_rst_correct", bus.sym_correct, 1);
        chk("mid_rst_sym_error", bus.sym_error, 0);
        chk("mid_rst_power", bus.err_power, 0);
        chk("mid_rst_count", bus.err_count, 0);
        chk("mid_rst_mv", bus.meas_valid, 0);
        chk("mid_rst_clear", bus.clear_accum, 0);
        reset = 1'b0;
        model_reset();
        start_run(2, 1'b0);
        ticks_to_mv(100, k);
        chk("post_rst_latency", k, 19);
        chk("post_rst_power", bus.err_power, 10000);

        // Abort at symbol 7; delay_sel change while running must not disturb alignment.
        exact_ticks(3, 300);
        bus.delay_sel = 3'd5;
        exact_ticks(4, 300);
        chk("shadow_delay_correct", bus.sym_correct, 1);
        chk("shadow_delay_error", bus.error, 300);
        stop_run();
        for (int t = 0; t < 3; t++) sym_tick(int'($urandom_range(0, 3)), 777);
        chk("abort_power", bus.err_power, 10000);
        chk("abort_count", bus.err_count, 0);
        start_run(5, 1'b0);
        ticks_to_mv(0, k);
        chk("restart_latency", k, 22);
        chk("restart_power", bus.err_power, 0);
        stop_run();

        // Randomized runs against the model.
        for (int seg = 0; seg < 10; seg++) begin
            bus.ref_level = ($urandom_range(0, 5) == 0) ? '0 : WIDTH'($urandom_range(1, 20000));
            ds = int'($urandom_range(0, MAX_DELAY - 1));
            dd = 1'($urandom_range(0, 1));
            start_run(ds, dd);
            nt = int'($urandom_range(10, 60));
            for (int t = 0; t < nt; t++) begin
                rs = int'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) nz = int'($urandom_range(0, 60000)) - 30000;
                else                           nz = int'($urandom_range(0, 2000)) - 1000;
                if (t == 5) bus.delay_sel = 3'($urandom_range(0, MAX_DELAY - 1));
                sym_tick(rs, clampv(map_i(aligned(rs), int'(bus.ref_level)) + nz));
            end
            stop_run();
            sym_tick(int'($urandom_range(0, 3)), int'($urandom_range(0, 40000)) - 20000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
